// File: rtl/cam_px_capture.sv
// OV7670 pixel receiver: RGB565 byte pairs -> RGB444 frame-buffer writes.
// Build option CAM_TESTPAT_EN replaces camera data with colour bars.
module cam_px_capture #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr,
  output logic [11:0]   DP_RAM_data,
  output logic          DP_RAM_we,
  output logic          frame_done
);

  localparam int CWN = $clog2(IMG_W + 1);
  localparam int CW  = (CWN < 8) ? 8 : CWN;
  localparam int LW  = $clog2(IMG_H + 1);

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W);
  localparam logic [LW-1:0] LINE_MAX = LW'(IMG_H);
  localparam logic [AW-1:0] ADDR_MAX = AW'(IMG_W * IMG_H - 1);

  localparam logic [2:0] ST_SYNC   = 3'd0;
  localparam logic [2:0] ST_VBLANK = 3'd1;
  localparam logic [2:0] ST_HWAIT  = 3'd2;
  localparam logic [2:0] ST_BYTE1  = 3'd3;
  localparam logic [2:0] ST_BYTE2  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_d;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [7:0]    byte1;
  logic          pend;
  logic [11:0]   pend_data;
  logic [AW-1:0] pend_addr;

  logic in_sync;
  logic in_vblank;
  logic in_hwait;
  logic in_b1;
  logic in_b2;

  logic take_b1;
  logic take_b2;
  logic line_end;
  logic abort;
  logic clr_frame;

  logic          store_ok;
  logic [11:0]   px_word;
  logic [AW-1:0] px_addr;

  assign in_sync   = (state == ST_SYNC);
  assign in_vblank = (state == ST_VBLANK);
  assign in_hwait  = (state == ST_HWAIT);
  assign in_b1     = (state == ST_BYTE1);
  assign in_b2     = (state == ST_BYTE2);

  always_comb begin
    state_d   = state;
    take_b1   = 1'b0;
    take_b2   = 1'b0;
    line_end  = 1'b0;
    abort     = 1'b0;
    clr_frame = 1'b0;
    unique case (1'b1)
      in_sync: begin
        if (CAM_vsync) state_d = ST_VBLANK;
      end
      in_vblank: begin
        if (!CAM_vsync) begin
          clr_frame = 1'b1;
          state_d   = ST_HWAIT;
        end
      end
      in_hwait: begin
        if (CAM_vsync) begin
          abort   = 1'b1;
          state_d = ST_VBLANK;
        end else if (CAM_href) begin
          take_b1 = 1'b1;
          state_d = ST_BYTE2;
        end
      end
      in_b1: begin
        if (CAM_vsync) begin
          abort   = 1'b1;
          state_d = ST_VBLANK;
        end else if (CAM_href) begin
          take_b1 = 1'b1;
          state_d = ST_BYTE2;
        end else begin
          line_end = 1'b1;
          state_d  = ST_HWAIT;
        end
      end
      in_b2: begin
        if (CAM_vsync) begin
          abort   = 1'b1;
          state_d = ST_VBLANK;
        end else if (CAM_href) begin
          take_b2 = 1'b1;
          state_d = ST_BYTE1;
        end else begin
          line_end = 1'b1;
          state_d  = ST_HWAIT;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign store_ok = (col < COL_MAX) && (line < LINE_MAX);
  assign px_addr  = AW'(line) * AW'(IMG_W) + AW'(col);

`ifdef CAM_TESTPAT_EN
  logic unused_px;
  assign unused_px = ^{CAM_px_data, byte1};
  assign px_word = {{4{col[7]}}, {4{col[6]}}, {4{col[5]}}};
`else
  logic unused_px;
  assign unused_px = ^{byte1[3], CAM_px_data[6:5], CAM_px_data[0]};
  // Keep the top bits of each RGB565 field; lower bits are truncated
  assign px_word = {byte1[7:4], byte1[2:0], CAM_px_data[7],
                    CAM_px_data[4:1]};
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= ST_SYNC;
      col         <= '0;
      line        <= '0;
      byte1       <= '0;
      pend        <= 1'b0;
      pend_data   <= '0;
      pend_addr   <= '0;
      DP_RAM_addr <= '0;
      DP_RAM_data <= '0;
      DP_RAM_we   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= abort;
      DP_RAM_we  <= pend;
      pend       <= take_b2 && store_ok;

      if (take_b1) byte1 <= CAM_px_data;

      if (take_b2) begin
        pend_data <= px_word;
        pend_addr <= px_addr;
        col       <= (col == COL_MAX) ? col : col + 1'b1;
      end

      if (line_end) begin
        col  <= '0;
        line <= (line == LINE_MAX) ? line : line + 1'b1;
      end

      if (DP_RAM_we && (DP_RAM_addr != ADDR_MAX))
        DP_RAM_addr <= DP_RAM_addr + 1'b1;

      // Write lands one pclk after the second byte is sampled
      if (pend) begin
        DP_RAM_addr <= pend_addr;
        DP_RAM_data <= pend_data;
      end

      if (clr_frame) begin
        DP_RAM_addr <= '0;
        col         <= '0;
        line        <= '0;
      end
    end
  end

endmodule
